// File: rtl/alu_cmd_sequencer.sv
// Registers commands onto a combinational ALU, captures its result one cycle later,
// and hands the result off over valid/ready while keeping a chaining accumulator.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_acc,
    input  logic              acc_clr,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic [FLAG_W-1:0] alu_flag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic [FLAG_W-1:0] res_flag,
    output logic [WIDTH-1:0]  acc,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [FLAG_W-1:0]  res_flag_q, res_flag_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
    logic               accept;

    // In HOLD a new command may only enter when the current result leaves on the same edge.
    assign cmd_ready = (state_q == StIdle) || ((state_q == StHold) && res_ready);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flag_d  = res_flag_q;
        acc_d       = acc_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                res_data_d  = alu_out;
                res_flag_d  = alu_flag;
                acc_d       = alu_out;
                res_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (res_ready) begin
                    op_count_d  = op_count_q + CNT_W'(1);
                    res_valid_d = 1'b0;
                    state_d     = cmd_valid ? StExec : StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                res_valid_d = 1'b0;
            end
        endcase

        if (accept) begin
            alu_a_d   = cmd_acc ? (acc_clr ? '0 : acc_q) : cmd_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_sel;
        end

        // Clear wins over the EXEC capture; res_data still reports the raw result.
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= '0;
            acc_q       <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flag_q  <= res_flag_d;
            acc_q       <= acc_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flag  = res_flag_q;
    assign acc       = acc_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a stand-in ALU, a transaction-level model checked every
// cycle, and literal checks of the directed scenarios.
module tb_alu_cmd_sequencer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_a = '0;
    logic [WIDTH-1:0]  cmd_b = '0;
    logic [SEL_W-1:0]  cmd_sel = '0;
    logic              cmd_acc = 1'b0;
    logic              acc_clr = 1'b0;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [WIDTH-1:0]  alu_out;
    logic [FLAG_W-1:0] alu_flag;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [WIDTH-1:0]  res_data;
    logic [FLAG_W-1:0] res_flag;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  op_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alu_cmd_sequencer #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .FLAG_W(FLAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_sel  (cmd_sel),
        .cmd_acc  (cmd_acc),
        .acc_clr  (acc_clr),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .alu_flag (alu_flag),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_flag (res_flag),
        .acc      (acc),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_res(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [SEL_W-1:0] s);
        case (s)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return 8'hE5;
        endcase
    endfunction

    function automatic logic [FLAG_W-1:0] alu_flg(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [SEL_W-1:0] s);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        wide = {1'b0, a} + {1'b0, b};
        r    = alu_res(a, b, s);
        return {(s == 4'h0) && wide[WIDTH], r == '0, r[WIDTH-1], ^r};
    endfunction

    // Stand-in for m_alu.
    always_comb begin
        alu_out  = alu_res(alu_a, alu_b, alu_sel);
        alu_flag = alu_flg(alu_a, alu_b, alu_sel);
    end

    // Transaction model: one pending operation, one outstanding result.
    bit               m_pending = 0;
    bit               m_outstanding = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0, m_acc = '0;
    logic [SEL_W-1:0] m_sel = '0;
    logic [FLAG_W-1:0] m_flag = '0;
    logic [CNT_W-1:0] m_cnt = '0;

    function automatic bit model_ready();
        return !m_pending && (!m_outstanding || res_ready);
    endfunction

    always @(posedge clk) begin
        bit take, acc_in;
        logic [WIDTH-1:0] acc_old;
        if (!rst_n) begin
            m_pending = 0; m_outstanding = 0;
            m_a = '0; m_b = '0; m_sel = '0; m_res = '0; m_flag = '0; m_acc = '0; m_cnt = '0;
        end else begin
            acc_in  = cmd_valid && model_ready();
            take    = m_outstanding && res_ready;
            acc_old = m_acc;
            if (take) begin
                m_cnt = m_cnt + 1'b1;
                m_outstanding = 0;
            end
            if (m_pending) begin
                m_res  = alu_res(m_a, m_b, m_sel);
                m_flag = alu_flg(m_a, m_b, m_sel);
                m_acc  = m_res;
                m_outstanding = 1;
            end
            if (acc_clr) m_acc = '0;
            m_pending = acc_in;
            if (acc_in) begin
                m_a   = cmd_acc ? (acc_clr ? '0 : acc_old) : cmd_a;
                m_b   = cmd_b;
                m_sel = cmd_sel;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(model_ready()));
            check("alu_a", 32'(alu_a), 32'(m_a));
            check("alu_b", 32'(alu_b), 32'(m_b));
            check("alu_sel", 32'(alu_sel), 32'(m_sel));
            check("res_valid", 32'(res_valid), 32'(m_outstanding));
            check("res_data", 32'(res_data), 32'(m_res));
            check("res_flag", 32'(res_flag), 32'(m_flag));
            check("acc", 32'(acc), 32'(m_acc));
            check("op_count", 32'(op_count), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                           input logic use_acc);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s; cmd_acc = use_acc;
    endtask

    logic [7:0] bb_a [4] = '{8'h20, 8'hF0, 8'h0C, 8'h33};
    logic [7:0] bb_b [4] = '{8'h05, 8'h3C, 8'h30, 8'h44};
    logic [3:0] bb_s [4] = '{4'h0, 4'h2, 4'h3, 4'hF};

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_valid", 32'(res_valid), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_count", 32'(op_count), 0);

        // Basic add
        set_cmd(8'h01, 8'h02, 4'h0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        check("add_alu_a", 32'(alu_a), 32'h01);
        check("add_busy", 32'(cmd_ready), 0);
        tick();
        check("add_valid", 32'(res_valid), 1);
        check("add_data", 32'(res_data), 32'h03);
        check("add_acc", 32'(acc), 32'h03);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("add_count", 32'(op_count), 1);

        // Chaining: cmd_a ignored
        set_cmd(8'hFF, 8'h04, 4'h0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("chain_alu_a", 32'(alu_a), 32'h03);
        tick();
        check("chain_data", 32'(res_data), 32'h07);
        check("chain_acc", 32'(acc), 32'h07);

        // Backpressure with a command waiting
        set_cmd(8'h05, 8'h03, 4'h1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_ready", 32'(cmd_ready), 0);
            check("bp_data", 32'(res_data), 32'h07);
            check("bp_count", 32'(op_count), 1);
        end
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("bp_take_count", 32'(op_count), 2);
        check("bp_accept_a", 32'(alu_a), 32'h05);
        tick();
        check("bp_sub_data", 32'(res_data), 32'h02);
        tick();

        // Back-to-back with res_ready held high
        for (int i = 0; i < 4; i++) begin
            set_cmd(bb_a[i], bb_b[i], bb_s[i], 1'b0);
            tick();
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        check("b2b_count", 32'(op_count), 7);
        check("b2b_last_data", 32'(res_data), 32'hE5);

        // acc_clr coincident with accept using the accumulator
        set_cmd(8'h99, 8'h02, 4'h0, 1'b1);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        cmd_valid = 1'b0;
        check("clr_accept_a", 32'(alu_a), 0);
        tick();
        check("clr_accept_data", 32'(res_data), 32'h02);
        tick();

        // acc_clr during EXEC
        res_ready = 1'b0;
        set_cmd(8'h10, 8'h01, 4'h0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("clr_exec_data", 32'(res_data), 32'h11);
        check("clr_exec_acc", 32'(acc), 0);
        res_ready = 1'b1;
        tick();

        // Reset during EXEC
        set_cmd(8'h40, 8'h02, 4'h0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(res_valid), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        check("mid_rst_data", 32'(res_data), 0);
        check("mid_rst_acc", 32'(acc), 0);
        check("mid_rst_alu_a", 32'(alu_a), 0);
        check("mid_rst_count", 32'(op_count), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_result", 32'(res_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
